// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the async FIFO pointer/status generators.
//   FIFO_ADDRSIZE : default RAM address width
//   fifo_depth()  : number of RAM entries for a given address width
//   bin2gray()    : binary to reflected Gray code (zero-extended to 32 bits)
//   gray2bin()    : reflected Gray code to binary (zero-extended to 32 bits)
// Both code converters work on any narrower width as long as the unused
// upper bits are zero, so the read and write sides can share them.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_ADDRSIZE = 4;

    function automatic int unsigned fifo_depth(input int unsigned addrsize);
        return 32'd1 << addrsize;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return (bin >> 1) ^ bin;
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i + 1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// -----------------------------------------------------------------------------
// fifo_gray2bin
// Combinational Gray-to-binary converter. Each binary bit is the XOR of all
// Gray bits at and above its position (XOR prefix from the MSB).
// Ports:
//   gray : input  [WIDTH-1:0]  Gray-coded value
//   bin  : output [WIDTH-1:0]  binary equivalent
// -----------------------------------------------------------------------------
module fifo_gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/wptr_full_gen.sv
// -----------------------------------------------------------------------------
// wptr_full_gen
// Write-domain pointer and status generator for the async FIFO. Consumes the
// synchronized Gray read pointer and produces the RAM write address, the Gray
// write pointer and registered full / almost-full / level / overflow status.
// Ports (all in the wclk domain):
//   wclk, wrst_n  : clock, asynchronous active-low reset
//   winc          : write request, accepted only while wfull=0
//   wq2_rptr      : synchronized read pointer (Gray, ADDRSIZE+1 bits)
//   wovf_clr      : clears sticky overflow (sticky build only)
//   waddr         : RAM write address (binary)
//   wptr          : Gray write pointer to the write-to-read synchronizer
//   wfull         : FIFO full
//   walmost_full  : free slots <= AF_MARGIN
//   wlevel        : occupied entries as seen by the writer, 0..DEPTH
//   woverflow     : write attempted while full
// Build option: WPTR_OVF_STICKY_EN makes woverflow sticky until wovf_clr;
// without it woverflow is a one-cycle pulse and wovf_clr is ignored.
// -----------------------------------------------------------------------------
module wptr_full_gen
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE  = FIFO_ADDRSIZE,
    parameter int AF_MARGIN = 2
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                wovf_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                woverflow
);

    localparam int DEPTH = int'(fifo_depth(ADDRSIZE));
    localparam int PW    = ADDRSIZE + 1;  // pointer width
    localparam int LW    = ADDRSIZE + 2;  // one guard bit for the free-slot math

    logic [PW-1:0] wbin_q,  wbin_d;
    logic [PW-1:0] wptr_q,  wptr_d;
    logic          wfull_q, wfull_d;
    logic          waf_q,   waf_d;
    logic [PW-1:0] wlevel_q, wlevel_d;
    logic          wovf_q,  wovf_d;

    logic          wen_s;
    logic          ovf_evt_s;
    logic [PW-1:0] rbin_s;
    logic [LW-1:0] free_s;

    fifo_gray2bin #(
        .WIDTH (PW)
    ) u_rptr_g2b (
        .gray (wq2_rptr),
        .bin  (rbin_s)
    );

`ifndef WPTR_OVF_STICKY_EN
    // Clear input has no function in pulse mode.
    logic unused_ovf_clr_s;
    assign unused_ovf_clr_s = wovf_clr;
`endif

    // Next-state for pointers, flags and level.
    always_comb begin
        wen_s     = winc & ~wfull_q;
        ovf_evt_s = winc & wfull_q;

        wbin_d = wbin_q + {{ADDRSIZE{1'b0}}, wen_s};
        wptr_d = (wbin_d >> 1) ^ wbin_d;

        // Full when the next write pointer equals the read pointer with the
        // two MSBs inverted (one lap ahead in Gray space).
        wfull_d = (wptr_d == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});

        // Modulo subtraction yields 0..DEPTH because the pointers never
        // drift more than one lap apart.
        wlevel_d = wbin_d - rbin_s;
        free_s   = LW'(DEPTH) - {1'b0, wlevel_d};
        waf_d    = (free_s <= LW'(AF_MARGIN));

`ifdef WPTR_OVF_STICKY_EN
        // Set dominates a simultaneous clear.
        wovf_d = ovf_evt_s | (wovf_q & ~wovf_clr);
`else
        wovf_d = ovf_evt_s;
`endif
    end

    // State and status registers.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q   <= {PW{1'b0}};
            wptr_q   <= {PW{1'b0}};
            wfull_q  <= 1'b0;
            waf_q    <= 1'b0;
            wlevel_q <= {PW{1'b0}};
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wfull_q  <= wfull_d;
            waf_q    <= waf_d;
            wlevel_q <= wlevel_d;
            wovf_q   <= wovf_d;
        end
    end

    assign waddr        = wbin_q[ADDRSIZE-1:0];
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = waf_q;
    assign wlevel       = wlevel_q;
    assign woverflow    = wovf_q;

endmodule

// File: tb/tb_wptr_full_gen.sv
// -----------------------------------------------------------------------------
// tb_wptr_full_gen
// Directed bench for wptr_full_gen with ADDRSIZE=4, AF_MARGIN=2.
// -----------------------------------------------------------------------------
module tb_wptr_full_gen;

    logic       wclk;
    logic       wrst_n;
    logic       winc;
    logic [4:0] wq2_rptr;
    logic       wovf_clr;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic       woverflow;

    int checks_cnt = 0;
    int errors_cnt = 0;

    wptr_full_gen #(
        .ADDRSIZE  (4),
        .AF_MARGIN (2)
    ) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .wovf_clr     (wovf_clr),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .woverflow    (woverflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".waddr"}, 32'(waddr), 32'd0);
        check({tag, ".wptr"}, 32'(wptr), 32'd0);
        check({tag, ".wfull"}, 32'(wfull), 32'd0);
        check({tag, ".waf"}, 32'(walmost_full), 32'd0);
        check({tag, ".wlevel"}, 32'(wlevel), 32'd0);
        check({tag, ".wovf"}, 32'(woverflow), 32'd0);
    endtask

    function automatic logic [4:0] gray5(input int unsigned b);
        logic [4:0] v;
        v = 5'(b);
        return (v >> 1) ^ v;
    endfunction

    task automatic do_reset();
        wrst_n   = 1'b0;
        wq2_rptr = 5'd0;
        wovf_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            winc = ~winc;
            step();
        end
        check_all_zero("rst");
        winc   = 1'b0;
        wrst_n = 1'b1;
        step();
        check("rst.idle_waddr", 32'(waddr), 32'd0);
    endtask

    initial begin
        winc     = 1'b0;
        wrst_n   = 1'b0;
        wq2_rptr = 5'd0;
        wovf_clr = 1'b0;

        // ---------------- reset ----------------
        do_reset();

        // ---------------- fill ----------------
        winc = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            check("fill.wlevel", 32'(wlevel), 32'(k));
            check("fill.waddr", 32'(waddr), 32'(k % 16));
            check("fill.wptr", 32'(wptr), 32'(gray5(k)));
            check("fill.waf", 32'(walmost_full), (k >= 14) ? 32'd1 : 32'd0);
            check("fill.wfull", 32'(wfull), (k == 16) ? 32'd1 : 32'd0);
        end
        check("fill.wptr_full", 32'(wptr), 32'h18);

        // ---------------- overflow ----------------
        for (int k = 0; k < 2; k++) begin
            step();
            check("ovf.wptr", 32'(wptr), 32'h18);
            check("ovf.waddr", 32'(waddr), 32'd0);
            check("ovf.wlevel", 32'(wlevel), 32'd16);
            check("ovf.wfull", 32'(wfull), 32'd1);
            check("ovf.wovf", 32'(woverflow), 32'd1);
        end
        winc = 1'b0;
        step();
`ifdef WPTR_OVF_STICKY_EN
        check("ovf.sticky_hold", 32'(woverflow), 32'd1);
        wovf_clr = 1'b1;
        step();
        wovf_clr = 1'b0;
        check("ovf.sticky_clr", 32'(woverflow), 32'd0);
`else
        check("ovf.pulse_end", 32'(woverflow), 32'd0);
`endif
        check("ovf.still_full", 32'(wfull), 32'd1);

        // ---------------- drain one, refill ----------------
        wq2_rptr = 5'b00001;
        step();
        check("drain.wfull", 32'(wfull), 32'd0);
        check("drain.wlevel", 32'(wlevel), 32'd15);
        check("drain.waf", 32'(walmost_full), 32'd1);
        winc = 1'b1;
        step();
        winc = 1'b0;
        check("refill.wfull", 32'(wfull), 32'd1);
        check("refill.wlevel", 32'(wlevel), 32'd16);
        check("refill.waddr", 32'(waddr), 32'd1);
        check("refill.wptr", 32'(wptr), 32'(gray5(17)));
        check("refill.wovf", 32'(woverflow), 32'd0);

        // ---------------- wrap with trailing reader ----------------
        do_reset();
        winc = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            check("wrap.waddr", 32'(waddr), 32'(k % 16));
            check("wrap.msb", 32'(wptr[4]), 32'((k >> 4) & 1));
            check("wrap.wlevel", 32'(wlevel), (k < 2) ? 32'(k) : 32'd2);
            check("wrap.wfull", 32'(wfull), 32'd0);
            check("wrap.waf", 32'(walmost_full), 32'd0);
            // Reader sits two writes behind at the next sampling edge.
            wq2_rptr = gray5((k >= 1) ? (k - 1) : 0);
        end
        winc = 1'b0;

        // ---------------- reset mid-fill ----------------
        do_reset();
        winc = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
        end
        check("mid.wlevel9", 32'(wlevel), 32'd9);
        check("mid.waddr9", 32'(waddr), 32'd9);
        #2;
        wrst_n = 1'b0;
        #1;
        check_all_zero("mid.async");
        #2;
        wrst_n = 1'b1;
        check("mid.restart_addr", 32'(waddr), 32'd0);
        step();
        check("mid.after_waddr", 32'(waddr), 32'd1);
        check("mid.after_wlevel", 32'(wlevel), 32'd1);
        winc = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/wptr_full_gen.md
Name: wptr_full_gen

Overview:
- Write-domain pointer and status generator for the async FIFO.
- Sits directly downstream of the read-to-write pointer synchronizer and consumes its two-flop-synchronized Gray read pointer.
- Produces the RAM write address, the Gray write pointer (sent to the write-to-read synchronizer), and the registered full, almost-full, level and overflow status.
- All logic is in the write clock domain.

Parameters:
- ADDRSIZE, 4, RAM address width; FIFO depth DEPTH = 2^ADDRSIZE.
- AF_MARGIN, 2, walmost_full asserts when free slots <= AF_MARGIN; legal range 1..DEPTH-1.

Ports:
- wclk  input  1  write clock.
- wrst_n  input  1  reset, asynchronous, active-low.
- winc  input  1  write request; accepted only when wfull=0.
- wq2_rptr  input  ADDRSIZE+1  synchronized read pointer, Gray code.
- wovf_clr  input  1  clears sticky overflow (feature-dependent).
- waddr  output  ADDRSIZE  RAM write address (binary).
- wptr  output  ADDRSIZE+1  write pointer, Gray code, registered.
- wfull  output  1  FIFO full, registered.
- walmost_full  output  1  free slots <= AF_MARGIN, registered.
- wlevel  output  ADDRSIZE+1  occupied entries as seen by the writer, 0..DEPTH.
- woverflow  output  1  write attempted while full.

Behaviour:
- Reset: one clock (wclk); reset is asynchronous and active-low (wrst_n).
- Reset values: wbin=0, wptr=0, waddr=0, wfull=0, walmost_full=0, wlevel=0, woverflow=0. Reset takes effect immediately, including mid-operation.
- Write accept: wen = winc & ~wfull.
- Pointers:
  - wbinnext = wbin + wen, modulo 2^(ADDRSIZE+1).
  - wgraynext = (wbinnext>>1) ^ wbinnext.
  - wbin and wptr register wbinnext and wgraynext on every wclk.
  - waddr = wbin[ADDRSIZE-1:0]; the RAM writes at the current waddr when wen=1.
- Full:
  - wfull <= (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
  - Full therefore asserts on the same edge that accepts the DEPTH-th outstanding write (zero-cycle pessimism on set).
  - Full deasserts one wclk after wq2_rptr advances.
- Level:
  - rbin_s = Gray-to-binary of wq2_rptr.
  - wlevel <= (wbinnext - rbin_s), modulo 2^(ADDRSIZE+1). This is always in 0..DEPTH, and equals DEPTH exactly when wfull is set.
- Almost full: walmost_full <= ((DEPTH - level_next) <= AF_MARGIN), where level_next is the value being loaded into wlevel.
- Overflow event: winc=1 while wfull=1. The pointer does not move and nothing is written.
- Simultaneous write and read advance: both terms are taken in the same next-state computation, so the level is unchanged and full stays clear.
- Pessimism: the read pointer lags by 2+ wclk, so wlevel and the flags are conservative (never under-report occupancy).
- Wrap: the MSB of wbin toggles every DEPTH writes; waddr wraps from DEPTH-1 to 0.
- X-free: wq2_rptr must only change by one Gray bit per wclk; the block does not check this.

Optional Feature:
- Macro: WPTR_OVF_STICKY_EN.
- Defined:
  - woverflow sets on an overflow event and holds until a wclk with wovf_clr=1.
  - If set and clear occur in the same cycle, set wins.
- Undefined:
  - woverflow is a one-cycle registered pulse, high in the cycle after each overflow event.
  - wovf_clr is ignored.

Decomposition:
- Shared package fifo_pkg:
  - default ADDRSIZE constant;
  - depth function 2^ADDRSIZE;
  - bin2gray and gray2bin functions, reused by the read-side empty generator.
- One natural sub-module: fifo_gray2bin, a parameterized XOR-prefix converter instantiated for wq2_rptr.
- The binary-to-Gray conversion stays inline.

Test Plan (ADDRSIZE=4, DEPTH=16, AF_MARGIN=2):
- Reset: hold wrst_n=0 with winc=1 toggling -> all outputs 0. Release -> first accepted write is at waddr=0.
- Fill: wq2_rptr=0, winc=1 for 16 cycles -> wlevel counts 1..16 and walmost_full rises at wlevel=14. wfull=1 on the edge of the 16th write, with wptr=5'b11000 and waddr=0.
- Overflow: full, then winc=1 for 2 cycles -> wptr, waddr and wlevel unchanged.
  - Pulse mode: woverflow high 2 cycles.
  - Sticky mode: woverflow stays high until wovf_clr, then clears the next cycle.
- Drain: while full, wq2_rptr goes 0 -> 5'b00001 -> wfull=0 one wclk later, wlevel=15, walmost_full still 1. Next winc refills to full.
- Wrap: 40 writes with wq2_rptr tracking wptr delayed 2 cycles -> waddr wraps 15->0 twice, wbin MSB toggles, wfull never set, wlevel<=2.
- Reset mid-fill: after 9 writes, pulse wrst_n low asynchronously between edges -> outputs clear immediately and waddr restarts at 0.
